// File: rtl/multdiv_unit_if.sv
// Operand/request and result bus of the iterative multiply/divide unit.
// master drives operands and start pulses; slave returns the result, exception flag and ready pulse.
interface multdiv_unit_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) on magnitudes with a sign fixup.
// Latency: 32 cycles from the start edge to a one-cycle data_resultRDY pulse.
// Backpressure: none; a new start edge aborts the op in flight and the pipeline stalls on the ready pulse.
module multdiv_unit (
    input  logic           clock,
    input  logic           reset_n,
    multdiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] acc;
    logic [31:0] result_q;
    logic        exc_q;

    logic        start;
    logic        last_step;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // 0x80000000 maps onto itself, which is exactly its magnitude read as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign start     = bus.ctrl_MULT ^ bus.ctrl_DIV;
    assign last_step = (state == S_RUN) && (cnt == 6'd31);
    assign abs_a     = magnitude(bus.data_operandA);
    assign abs_b     = magnitude(bus.data_operandB);

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_RUN:   state_nxt = (cnt == 6'd31) ? S_DONE : S_RUN;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.data_resultRDY = (state == S_DONE);
        bus.data_result    = result_q;
        bus.data_exception = exc_q;
    end

    // ---------------- shared datapath step ----------------
    // Multiply: acc = {partial product high, multiplier shifting out low}.
    // Divide:   acc = {partial remainder, dividend shifting out / quotient shifting in}.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = (div_shift >= {1'b0, mag_b});
        if (is_div) begin
            // The remainder stays below |B| <= 2^31, so 32 bits hold it between steps.
            acc_step = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc[30:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    // ---------------- sign fixup and exception ----------------
    logic [63:0] prod_signed;
    logic [31:0] quo;
    logic [31:0] quo_signed;
    logic        div_by_zero;
    logic [31:0] result_nxt;
    logic        exc_nxt;

    always_comb begin
        prod_signed = neg ? (64'd0 - acc_step) : acc_step;
        quo         = acc_step[31:0];
        quo_signed  = neg ? (32'd0 - quo) : quo;
        div_by_zero = (mag_b == 32'd0);
        result_nxt  = prod_signed[31:0];
        exc_nxt     = (prod_signed[63:32] != {32{prod_signed[31]}});
        if (is_div) begin
            // A positive quotient of 2^31 only arises from 0x80000000 / -1.
            result_nxt = div_by_zero ? 32'd0 : quo_signed;
            exc_nxt    = div_by_zero | (quo[31] & ~neg);
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 6'd0;
            is_div <= 1'b0;
            neg    <= 1'b0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            acc    <= 64'd0;
        end else if (start) begin
            cnt    <= 6'd0;
            is_div <= bus.ctrl_DIV;
            neg    <= bus.data_operandA[31] ^ bus.data_operandB[31];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            acc    <= {32'd0, (bus.ctrl_DIV ? abs_a : abs_b)};
        end else if (state == S_RUN) begin
            cnt    <= cnt + 6'd1;
            acc    <= acc_step;
        end
    end

    // Results change only when entering DONE and hold until the next DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else if (last_step && !start) begin
            result_q <= result_nxt;
            exc_q    <= exc_nxt;
        end
    end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32-bit multiply/divide unit that sits beside the combinational ALU in the execute stage. The ALU covers single-cycle add/sub/logic/shift ops. This block covers the multi-cycle ones: multiplication, and its inverse, division. Both run over 32 iterations on a shared datapath, and completion is signalled by a one-cycle ready pulse that the pipeline stalls on.

## Interface
- No parameters; width fixed at 32.
- clock  input  1  rising-edge clock; one clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- data_operandA  input  32  two's-complement multiplicand / dividend; sampled only on a start edge.
- data_operandB  input  32  two's-complement multiplier / divisor; sampled only on a start edge.
- ctrl_MULT  input  1  start-multiply request; single-cycle pulse.
- ctrl_DIV  input  1  start-divide request; single-cycle pulse.
- data_result  output  32  low 32 bits of the product, or the quotient; registered.
- data_exception  output  1  overflow or divide-by-zero flag for data_result; registered.
- data_resultRDY  output  1  one-cycle pulse: data_result and data_exception are valid.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: 6-bit step counter 0..31.
  - DONE: one cycle.
- Start edge: a rising edge with exactly one of ctrl_MULT / ctrl_DIV high.
  - Latches the op type and |A|, |B|.
  - Latches sign flags: product/quotient sign = A[31]^B[31].
  - Clears the counter and enters RUN.
- Both ctrl_MULT and ctrl_DIV high on the same edge: no request. The current state continues unchanged.
- A start edge in RUN or DONE aborts the current op and restarts with the new operands. No ready pulse is produced for the aborted op.
- Multiply, unsigned radix-2 shift-add on magnitudes:
  - 64-bit accumulator; one partial-product step per RUN cycle.
  - Final result = 64-bit product, negated if the sign flag is set.
  - data_result = final[31:0].
  - data_exception = 1 iff final[63:32] is not all copies of final[31] (signed 32-bit overflow).
- Divide, restoring division on magnitudes:
  - One quotient bit per RUN cycle, MSB first.
  - 33-bit partial remainder.
  - Quotient is negated if the sign flag is set, giving truncation toward zero.
  - The remainder is discarded.
- Divide special cases:
  - B = 0: data_result = 0, data_exception = 1.
  - A = 0x80000000 with B = 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
  - All other divides: data_exception = 0.
- Magnitude of 0x80000000 is 0x80000000 taken as unsigned. The datapath must handle it without overflow.
- data_result and data_exception load only on entry to DONE. They hold their value until the next DONE.
- Reset (reset_n low, at any time, including mid-RUN):
  - Forces IDLE and clears the counter and all datapath registers.
  - data_result = 0, data_exception = 0, data_resultRDY = 0.
  - Takes effect immediately.
  - The first start edge after release behaves normally.

## Timing
- Start edge = E0. RUN performs steps on edges E1..E32.
- On E32 the final step, sign fixup, and exception evaluation are registered into the outputs, and the state becomes DONE.
- data_resultRDY is high for exactly the cycle between E32 and E33; latency is 32 cycles.
- Edge E33 returns the state to IDLE, unless E33 is itself a start edge, which begins a new op (back-to-back issue allowed).
- Operands may change freely after E0; they are not re-sampled.
- data_resultRDY is never high in IDLE or RUN, and never for two consecutive cycles.

## Test plan
- Multiply 6 × 7, start at E0:
  - data_resultRDY is low for 32 cycles, then pulses once.
  - data_result = 42, data_exception = 0.
- Signed multiply −3 × 5 (A = 0xFFFFFFFD) → data_result = 0xFFFFFFF1, exception 0.
- Overflowing multiply 0x00010000 × 0x00010000 → data_result = 0, exception 1.
- Signed divides:
  - −7 / 2 → 0xFFFFFFFD (−3), exception 0.
  - 5 / 0 → 0, exception 1.
  - 0x80000000 / −1 → 0x80000000, exception 1.
- Restart: start 100 / 7 at E0, then start 9 × 9 at E10.
  - No ready pulse near E32.
  - Single pulse after E42 with data_result = 81.
- Reset and simultaneous requests:
  - Drop reset_n mid-RUN: all outputs 0 immediately; no ready pulse afterwards.
  - Assert ctrl_MULT and ctrl_DIV together from IDLE: stays IDLE, no pulse.
